// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receive buffer between the UART receive frontend and the register
//            block. Each entry holds a received data byte plus its parity and
//            stop-bit error flags. Reads are show-ahead: the head entry is
//            always presented on the outputs.
//            An entry that arrives when the FIFO is full is dropped, and the
//            sticky overrun flag is set.
// Optional : `define UART_RX_FIFO_THRESHOLD_EN adds thresh_i/thresh_o, a
//            registered fill-level request (count >= thresh_i, thresh_i != 0).
// Ports    :
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                synchronous clear of pointers, count and overrun
//   valid_i, data_i,       frame from the receive frontend (1-cycle pulse)
//   parity_err_i,
//   frame_err_i
//   pop_i                  consume the head entry (1-cycle pulse)
//   data_o, parity_err_o,  head entry, all zero while empty
//   frame_err_o
//   empty_o, full_o,       registered status derived from the entry count
//   level_o
//   overrun_o              sticky drop flag
//   overrun_clr_i          clears overrun_o; a coincident drop wins
//   thresh_i, thresh_o     only with UART_RX_FIFO_THRESHOLD_EN
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       valid_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       parity_err_i,
    input  logic                       frame_err_i,
    input  logic                       pop_i,
    input  logic                       overrun_clr_i,
`ifdef UART_RX_FIFO_THRESHOLD_EN
    input  logic [$clog2(DEPTH):0]     thresh_i,
    output logic                       thresh_o,
`endif
    output logic [DATA_W-1:0]          data_o,
    output logic                       parity_err_o,
    output logic                       frame_err_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overrun_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + 2;

    // Entry layout: {parity_err, frame_err, data}
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [EW-1:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // A pop on a full FIFO frees the slot the push needs, so a push is only
    // refused when full with no pop. Flush discards any coincident frame.
    assign w_pop  = pop_i && !w_empty && !flush_i;
    assign w_push = valid_i && (!w_full || pop_i) && !flush_i;
    assign w_drop = valid_i && w_full && !pop_i && !flush_i;

    // Storage is not reset; the count gates what is visible.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {parity_err_i, frame_err_i, data_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else if (flush_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Drop has priority so a clear racing a new overrun never hides it.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign w_head       = r_mem[r_rptr];
    assign data_o       = w_empty ? '0   : w_head[DATA_W-1:0];
    assign frame_err_o  = w_empty ? 1'b0 : w_head[DATA_W];
    assign parity_err_o = w_empty ? 1'b0 : w_head[DATA_W+1];

    assign empty_o   = w_empty;
    assign full_o    = w_full;
    assign level_o   = r_count;
    assign overrun_o = r_overrun;

`ifdef UART_RX_FIFO_THRESHOLD_EN
    logic r_thresh;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_thresh <= 1'b0;
        end else begin
            r_thresh <= (r_count >= thresh_i) && (thresh_i != '0);
        end
    end

    assign thresh_o = r_thresh;
`endif

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer between the UART receive frontend and the memory-mapped register block. It captures each received frame's data byte together with its parity and frame error flags. The register block consumes the oldest entry when software reads the receive data register. Drives the RX-not-empty and overrun status and absorbs bursts while software is slow to drain.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 2
DATA_W, 8, data bits stored per entry

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  synchronous clear; asserted by the register block on a control register write
valid_i  input  1  one-cycle pulse from receive frontend, frame available
data_i  input  DATA_W  received data bits (frame[DATA_W-1:0])
parity_err_i  input  1  parity error flag for this frame
frame_err_i  input  1  stop-bit error flag for this frame
pop_i  input  1  one-cycle pulse, consume head entry (receive data register read)
data_o  output  DATA_W  head entry data
parity_err_o  output  1  head entry parity error flag
frame_err_o  output  1  head entry frame error flag
empty_o  output  1  no entries stored
full_o  output  1  DEPTH entries stored
level_o  output  $clog2(DEPTH)+1  number of stored entries
overrun_o  output  1  sticky; a frame was dropped because the FIFO was full
overrun_clr_i  input  1  clears overrun_o (status register read)

Behaviour:
- Storage: DEPTH x (DATA_W+2) array. Write pointer and read pointer are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH. Separate count register, 0..DEPTH.
- Reset (rst_ni low, async): pointers=0, count=0, overrun=0. Outputs: empty_o=1, full_o=0, level_o=0, overrun_o=0, data_o=0, parity_err_o=0, frame_err_o=0. Array contents are not reset.
- Show-ahead read: data_o/parity_err_o/frame_err_o present the head entry combinationally from the read pointer while count>0. All three are forced to 0 when empty.
- Push: valid_i && (!full || pop_i) -> write entry at wptr, wptr+1. The entry is visible at head the cycle after the write if the FIFO was empty (1-cycle latency).
- Pop: pop_i && !empty -> rptr+1. pop_i while empty is ignored, with no underflow and no state change.
- Count: +1 on accepted push only, -1 on effective pop only, unchanged when both occur or neither occurs.
- Full with push and pop in the same cycle: the pop frees a slot, so the push is accepted. Count stays DEPTH and no overrun is flagged.
- Empty with push and pop in the same cycle: the pop is ignored and the push is accepted, so count becomes 1.
- Full, valid_i without pop_i: the frame is dropped, storage is unchanged, and overrun is set the next cycle.
- overrun: set on drop, cleared by overrun_clr_i. If set and clear occur in the same cycle, set wins.
- flush_i: next cycle pointers=0, count=0, overrun=0. Flush overrides push, pop and overrun set in the same cycle. A valid_i coinciding with flush_i is discarded.
- empty_o = (count==0), full_o = (count==DEPTH), level_o = count. All are derived from registers, with no combinational path from inputs.

Optional Feature:
Macro UART_RX_FIFO_THRESHOLD_EN.
- Defined: adds input thresh_i ($clog2(DEPTH)+1 bits) and output thresh_o (1 bit). thresh_o = (count >= thresh_i) && (thresh_i != 0), registered, reset 0. Intended as an interrupt/DMA request.
- Not defined: neither port exists and no threshold logic is built.

Test Plan:
- Reset then idle -> empty_o=1, level_o=0, data_o=0, overrun_o=0. Pop while empty -> no change.
- Push 0x41 (pe=0, fe=0) -> next cycle empty_o=0, level_o=1, data_o=0x41. Pop -> empty_o=1, data_o=0.
- Push 0x00..0x0F with DEPTH=16 -> full_o=1, level_o=16. Push 0x55 -> dropped, overrun_o=1. Pop 16 times -> data 0x00..0x0F in order, 0x55 never seen.
- Full, simultaneous push 0xAA and pop -> level_o stays 16, overrun_o=0, 0xAA emerges last. Pointers wrap past index 15 correctly across 40 push/pop pairs.
- Push 0x12 with parity_err_i=1, then 0x34 with frame_err_i=1 -> head flags 1/0, then after pop 0/1. Overrun set and overrun_clr_i in the same cycle -> overrun_o=1.
- Level 5, flush_i with coincident valid_i -> level_o=0, empty_o=1, overrun_o=0. Assert rst_ni low mid-burst, asynchronously -> outputs reach reset values without a clock edge.
